// File: rtl/sr_seq_pkg.sv
// Shared types and helpers for the SR flag sequencer.
// FSM encoding, op polarity constants and a width helper.
package sr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        SETTLE
    } state_t;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_CLR = 1'b0;

    // Minimum of one bit so single-value counters and pointers still have a port.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr, wrapping modulo N.
// Purely combinational; no backpressure of its own, grants only among asserted requests.
module rr_arbiter
    import sr_seq_pkg::*;
#(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] win
);

    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        j     = 0;
        grant = '0;
        win   = '0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                win      = W'(j);
            end
        end
    end

endmodule

// File: rtl/sr_flag_sequencer.sv
// Arbitrates set/clear requests onto a shared SR flip-flop bank with one-hot S/R pulses.
// Accept in cycle 0, pulse for PULSE_CYCLES cycles, done one cycle later; req_ready holds off while busy.
module sr_flag_sequencer
    import sr_seq_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int NUM_FLAGS    = 8,
    parameter int IDX_W        = 3,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_op,
    input  logic [NUM_REQ*IDX_W-1:0] req_idx,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_FLAGS-1:0]     flag_q,
    output logic [NUM_FLAGS-1:0]     sr_s,
    output logic [NUM_FLAGS-1:0]     sr_r,
    output logic                     busy,
    output logic                     done,
    output logic                     err_range,
    output logic                     err_verify
);

    localparam int PTR_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(PULSE_CYCLES + 1);

    state_t               state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     win;
    logic [NUM_REQ-1:0]   grant;
    logic [CNT_W-1:0]     cnt;
    logic                 op_q;
    logic [NUM_FLAGS-1:0] hot_q;
    logic                 err_verify_q;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_op;
    logic [NUM_FLAGS-1:0] win_hot;
    logic                 accept;
    logic                 verify_miss;

    rr_arbiter #(.N(NUM_REQ), .W(PTR_W)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .win   (win)
    );

    assign req_ready = (state == IDLE && !rst) ? grant : '0;
    assign accept    = |(req_valid & req_ready);
    assign win_idx   = req_idx[int'(win)*IDX_W +: IDX_W];
    assign win_op    = req_op[win];
    // An out-of-range index shifts the bit off the top, leaving an all-zero mask.
    assign win_hot   = NUM_FLAGS'(1) << win_idx;

    assign verify_miss = (state == SETTLE) && (|hot_q) && ((|(flag_q & hot_q)) != op_q);
    assign err_verify  = err_verify_q | verify_miss;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            cnt          <= '0;
            op_q         <= 1'b0;
            hot_q        <= '0;
            sr_s         <= '0;
            sr_r         <= '0;
            done         <= 1'b0;
            err_range    <= 1'b0;
            err_verify_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q   <= win_op;
                        hot_q  <= win_hot;
                        cnt    <= '0;
                        rr_ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
                        if (|win_hot) begin
                            sr_s  <= (win_op == OP_SET) ? win_hot : '0;
                            sr_r  <= (win_op == OP_CLR) ? win_hot : '0;
                            state <= DRIVE;
                        end else begin
                            err_range <= 1'b1;
                            done      <= 1'b1;
                            state     <= SETTLE;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                        sr_s  <= '0;
                        sr_r  <= '0;
                        done  <= 1'b1;
                        state <= SETTLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                SETTLE: begin
                    done <= 1'b0;
                    if (verify_miss) err_verify_q <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sr_flag_sequencer.sv
// Bench for sr_flag_sequencer: directed scenarios plus randomized traffic against a transaction-level model.
// Two instances: PULSE_CYCLES=1 (index 0) and PULSE_CYCLES=3 (index 1), each driving a modelled SR bank.
module tb_sr_flag_sequencer;

    localparam int NR = 4;
    localparam int NF = 8;
    localparam int IW = 4;

    function automatic int pcyc(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst       [2];
    logic [NR-1:0] req_valid [2];
    logic [NR-1:0] req_op    [2];
    logic [NR*IW-1:0] req_idx[2];
    logic [NR-1:0] req_ready [2];
    logic [NF-1:0] flag_q    [2];
    logic [NF-1:0] sr_s      [2];
    logic [NF-1:0] sr_r      [2];
    logic [NF-1:0] bank      [2];
    logic [NF-1:0] force_lo  [2];
    logic          bank_clr  [2];
    logic          busy      [2];
    logic          done      [2];
    logic          err_range [2];
    logic          err_verify[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        sr_flag_sequencer #(
            .NUM_REQ(NR), .NUM_FLAGS(NF), .IDX_W(IW), .PULSE_CYCLES(g == 0 ? 1 : 3)
        ) u_dut (
            .clk        (clk),
            .rst        (rst[g]),
            .req_valid  (req_valid[g]),
            .req_op     (req_op[g]),
            .req_idx    (req_idx[g]),
            .req_ready  (req_ready[g]),
            .flag_q     (flag_q[g]),
            .sr_s       (sr_s[g]),
            .sr_r       (sr_r[g]),
            .busy       (busy[g]),
            .done       (done[g]),
            .err_range  (err_range[g]),
            .err_verify (err_verify[g])
        );
    end

    // SR flip-flop bank: S sets, R clears, otherwise hold.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bank_clr[i]) bank[i] <= '0;
            else             bank[i] <= (bank[i] | sr_s[i]) & ~sr_r[i];
        end
    end

    always_comb begin
        for (int i = 0; i < 2; i++) flag_q[i] = bank[i] & ~force_lo[i];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d, input bit clr);
        rst[d]       = 1'b1;
        req_valid[d] = '0;
        bank_clr[d]  = clr;
        step();
        step();
        rst[d]      = 1'b0;
        bank_clr[d] = 1'b0;
    endtask

    task automatic setreq(input int d, input int i, input bit op, input int idx);
        req_valid[d][i]         = 1'b1;
        req_op[d][i]            = op;
        req_idx[d][i*IW +: IW]  = IW'(idx);
    endtask

    // Transaction-level model: round-robin order, fixed latency, bank = last granted op per flag.
    task automatic rand_run(input int d, input int ncyc);
        int P = pcyc(d);
        int ptr = 0;
        int acc = -100;
        int dn = -100;
        int gprev = -1;
        int idxm = 0;
        int w;
        bit inr = 0;
        bit opm = 0;
        bit merr = 0;
        logic [NF-1:0] mbank = '0;
        logic [NF-1:0] exp_s, exp_r;
        logic [NR-1:0] exp_rdy;
        do_reset(d, 1'b1);
        for (int c = 0; c < ncyc; c++) begin
            exp_s = '0;
            exp_r = '0;
            if (inr && c >= acc + 1 && c <= acc + P) begin
                if (opm) exp_s = NF'(1) << idxm;
                else     exp_r = NF'(1) << idxm;
            end
            check("rnd_s_and_r", 32'(sr_s[d] & sr_r[d]), 32'h0);
            check("rnd_onehot", 32'($countones(sr_s[d] | sr_r[d]) <= 1), 32'h1);
            check("rnd_sr_s", 32'(sr_s[d]), 32'(exp_s));
            check("rnd_sr_r", 32'(sr_r[d]), 32'(exp_r));
            check("rnd_done", 32'(done[d]), 32'(c == dn));
            check("rnd_busy", 32'(busy[d]), 32'(c > acc && c <= dn));
            if (c == dn) check("rnd_bank", 32'(flag_q[d]), 32'(mbank));
            for (int i = 0; i < NR; i++) begin
                if (i == gprev) req_valid[d][i] = 1'b0;
                if (!req_valid[d][i] && $urandom_range(0, 2) == 0)
                    setreq(d, i, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 15) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7));
            end
            #1;
            exp_rdy = '0;
            w = -1;
            if (c > dn) begin
                for (int k = 0; k < NR; k++) begin
                    if (w < 0 && req_valid[d][(ptr + k) % NR]) w = (ptr + k) % NR;
                end
                if (w >= 0) exp_rdy = NR'(1) << w;
            end
            check("rnd_ready", 32'(req_ready[d]), 32'(exp_rdy));
            gprev = w;
            if (w >= 0) begin
                acc  = c;
                opm  = req_op[d][w];
                idxm = int'(req_idx[d][w*IW +: IW]);
                inr  = (idxm < NF);
                dn   = inr ? c + P + 1 : c + 1;
                ptr  = (w + 1) % NR;
                if (inr) mbank[idxm] = opm;
                else     merr = 1'b1;
            end
            step();
        end
        req_valid[d] = '0;
        repeat (P + 3) step();
        check("rnd_err_verify", 32'(err_verify[d]), 32'h0);
        check("rnd_err_range", 32'(err_range[d]), 32'(merr));
        check("rnd_final_bank", 32'(flag_q[d]), 32'(mbank));
    endtask

    initial begin
        logic [NR-1:0] e;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; req_valid[d] = '0; req_op[d] = '0; req_idx[d] = '0;
            force_lo[d] = '0; bank_clr[d] = 1'b1;
        end

        // Reset state, then a single set of flag 3 from requester 0.
        do_reset(0, 1'b1);
        check("rst_sr_s", 32'(sr_s[0]), 32'h0);
        check("rst_sr_r", 32'(sr_r[0]), 32'h0);
        check("rst_busy", 32'(busy[0]), 32'h0);
        check("rst_done", 32'(done[0]), 32'h0);
        check("rst_err_range", 32'(err_range[0]), 32'h0);
        check("rst_err_verify", 32'(err_verify[0]), 32'h0);
        setreq(0, 0, 1'b1, 3);
        #1;
        check("t1_ready", 32'(req_ready[0]), 32'h1);
        step();
        req_valid[0] = '0;
        check("t1_sr_s", 32'(sr_s[0]), 32'h08);
        check("t1_sr_r", 32'(sr_r[0]), 32'h0);
        check("t1_busy", 32'(busy[0]), 32'h1);
        check("t1_done_early", 32'(done[0]), 32'h0);
        step();
        check("t1_done", 32'(done[0]), 32'h1);
        check("t1_sr_s_off", 32'(sr_s[0]), 32'h0);
        check("t1_flag3", 32'(flag_q[0][3]), 32'h1);
        step();
        check("t1_done_off", 32'(done[0]), 32'h0);
        check("t1_idle", 32'(busy[0]), 32'h0);
        check("t1_err_range", 32'(err_range[0]), 32'h0);
        check("t1_err_verify", 32'(err_verify[0]), 32'h0);

        // Round-robin with all four requesters continuously valid.
        do_reset(0, 1'b0);
        for (int i = 0; i < NR; i++) setreq(0, i, 1'b1, i);
        for (int c = 0; c < 15; c++) begin
            #1;
            e = (c % 3 == 0) ? NR'(1 << ((c / 3) % NR)) : NR'(0);
            check($sformatf("rr_cycle%0d", c), 32'(req_ready[0]), 32'(e));
            step();
        end
        req_valid[0] = '0;
        repeat (3) step();
        check("rr_flags", 32'(flag_q[0] & 8'h0F), 32'h0F);

        // Out-of-range index 9.
        do_reset(0, 1'b0);
        setreq(0, 2, 1'b1, 9);
        #1;
        check("oor_ready", 32'(req_ready[0]), 32'h4);
        step();
        req_valid[0] = '0;
        check("oor_sr_s", 32'(sr_s[0]), 32'h0);
        check("oor_sr_r", 32'(sr_r[0]), 32'h0);
        check("oor_done", 32'(done[0]), 32'h1);
        check("oor_err_range", 32'(err_range[0]), 32'h1);
        step();
        check("oor_done_off", 32'(done[0]), 32'h0);
        check("oor_idle", 32'(busy[0]), 32'h0);
        check("oor_sr_s2", 32'(sr_s[0] | sr_r[0]), 32'h0);

        // Readback held low during a set of flag 5.
        force_lo[0] = 8'h20;
        setreq(0, 1, 1'b1, 5);
        #1;
        check("ver_ready", 32'(req_ready[0]), 32'h2);
        step();
        req_valid[0] = '0;
        check("ver_sr_s", 32'(sr_s[0]), 32'h20);
        step();
        check("ver_done", 32'(done[0]), 32'h1);
        check("ver_err_verify", 32'(err_verify[0]), 32'h1);
        step();
        check("ver_sticky", 32'(err_verify[0]), 32'h1);
        check("ver_done_off", 32'(done[0]), 32'h0);
        check("oor_sticky", 32'(err_range[0]), 32'h1);
        force_lo[0] = '0;

        rand_run(0, 5000);
        rand_run(1, 4000);

        // Reset during the second DRIVE cycle with PULSE_CYCLES=3.
        do_reset(1, 1'b0);
        setreq(1, 2, 1'b1, 6);
        #1;
        check("mid_ready", 32'(req_ready[1]), 32'h4);
        step();
        req_valid[1] = '0;
        check("mid_drive1", 32'(sr_s[1]), 32'h40);
        step();
        check("mid_drive2", 32'(sr_s[1]), 32'h40);
        check("mid_busy", 32'(busy[1]), 32'h1);
        rst[1] = 1'b1;
        step();
        rst[1] = 1'b0;
        check("mid_sr_s", 32'(sr_s[1]), 32'h0);
        check("mid_sr_r", 32'(sr_r[1]), 32'h0);
        check("mid_busy_off", 32'(busy[1]), 32'h0);
        check("mid_done", 32'(done[1]), 32'h0);
        for (int k = 0; k < 5; k++) begin
            step();
            check($sformatf("mid_no_done%0d", k), 32'(done[1]), 32'h0);
        end
        for (int i = 0; i < NR; i++) setreq(1, i, 1'b0, i);
        #1;
        check("mid_next_grant", 32'(req_ready[1]), 32'h1);
        step();
        req_valid[1] = '0;
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
